// File: rtl/uart_receiver_if.sv
// Receive-side byte stream: valid/ready byte delivery plus one-cycle error pulses.
// The master modport is the receiver and the slave modport is the downstream consumer.
interface uart_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, mid-bit sampling, valid/ready byte output; UART_RX_FIFO_EN selects a FIFO_DEPTH FIFO buffer.
// Latency: byte valid CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles after RxD falls (2 sync + 1 start detect).
// Backpressure: when the buffer is full a completed byte is dropped and overrun pulses; a same-cycle pop frees room.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RxD,
    uart_receiver_if.master bus
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 1) begin : g_param_check
        $error("uart_receiver: CLKS_PER_BIT must be >= 4 and FIFO_DEPTH >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          rx_meta;
    logic          rxs;
    logic          frame_err_q;
    logic          push;
    logic          pop;

    // Both stages reset high so a held-low line during reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        sr       <= {rxs, sr[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        // Returning to IDLE at mid-stop-bit lets the next start edge be caught with no gap.
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A good stop sample hands the byte to the buffer on the same edge.
    assign push = (state == STOP) && (baud_cnt == BIT_LAST) && rxs;

`ifdef UART_RX_FIFO_EN
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0] mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        accept;
    logic        overrun_q;

    // The extra top pointer bit separates a full FIFO from an empty one.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop    = !empty && bus.rx_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun_q <= push && !accept;
            if (accept) begin
                mem[wr_ptr[PW-1:0]] <= sr;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign bus.rx_data   = mem[rd_ptr[PW-1:0]];
    assign bus.rx_valid  = !empty;
    assign bus.overrun   = overrun_q;
`else
    logic [7:0] data_q;
    logic       valid_q;
    logic       overrun_q;

    assign pop = valid_q && bus.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (push && (!valid_q || pop)) begin
                data_q  <= sr;
                valid_q <= 1'b1;
            end else begin
                if (push) begin
                    overrun_q <= 1'b1;
                end
                if (pop) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.overrun   = overrun_q;
`endif

    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; builds with or without UART_RX_FIFO_EN.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    logic RxD;
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   pulse_long = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .RxD   (RxD),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if ((bus.frame_err && fe_prev) || (bus.overrun && ov_prev)) pulse_long++;
        end
        fe_prev = bus.frame_err;
        ov_prev = bus.overrun;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (bus.rx_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, bus.rx_valid, 1'b1);
        check({tag, "_data"}, bus.rx_data, exp);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int fe0;
        int ov0;

        RxD          = 1'b1;
        reset        = 1'b1;
        bus.rx_ready = 1'b0;

        // Reset with the line held low, released with the line idle.
        RxD = 1'b0;
        tick(3);
        check("rst_valid_in_reset", bus.rx_valid, 1'b0);
        RxD   = 1'b1;
        reset = 1'b0;
        tick(10);
        check("rst_valid", bus.rx_valid, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_data", bus.rx_data, 8'h00);
        check("rst_no_err_pulses", fe_cnt + ov_cnt, 0);

        // Frame 0xA5 with latency measurement from the RxD falling edge.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (bus.rx_valid !== 1'b1 && lat < 400) begin
                    tick(1);
                    lat++;
                end
            end
        join
        check("a5_latency", lat, 2 + 8 + 144 + 1);
        check("a5_data", bus.rx_data, 8'hA5);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("a5_valid_after_pop", bus.rx_valid, 1'b0);
`ifndef UART_RX_FIFO_EN
        check("a5_data_held", bus.rx_data, 8'hA5);
`endif

        // Short low glitch must be rejected at the mid-start sample.
        fe0 = fe_cnt;
        RxD = 1'b0;
        tick(5);
        RxD = 1'b1;
        tick(30);
        check("glitch_no_valid", bus.rx_valid, 1'b0);
        check("glitch_no_frame_err", fe_cnt - fe0, 0);
        send_frame(8'h3C, 1'b1);
        wait_valid(40);
        pop_check("glitch_next_3c", 8'h3C);
        check("glitch_next_emptied", bus.rx_valid, 1'b0);

        // Bad stop bit followed by a held break.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        RxD = 1'b0;
        tick(40);
        RxD = 1'b1;
        tick(20);
        check("break_one_frame_err", fe_cnt - fe0, 1);
        check("break_no_valid", bus.rx_valid, 1'b0);
        send_frame(8'h0F, 1'b1);
        wait_valid(40);
        pop_check("break_next_0f", 8'h0F);

        // Push and pop in the same cycle: new byte replaces the popped one, no overrun.
        send_frame(8'h11, 1'b1);
        wait_valid(40);
        check("pp_first_data", bus.rx_data, 8'h11);
        ov0 = ov_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(154);
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
                check("pp_valid_kept", bus.rx_valid, 1'b1);
                check("pp_new_data", bus.rx_data, 8'h22);
            end
        join
        check("pp_no_overrun", ov_cnt - ov0, 0);
        pop_check("pp_drain", 8'h22);
        check("pp_empty", bus.rx_valid, 1'b0);

        // Five back-to-back frames with the consumer stalled.
        ov0 = ov_cnt;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        send_frame(8'h05, 1'b1);
        tick(20);
`ifdef UART_RX_FIFO_EN
        check("b2b_overruns", ov_cnt - ov0, 1);
        pop_check("b2b_01", 8'h01);
        pop_check("b2b_02", 8'h02);
        pop_check("b2b_03", 8'h03);
        pop_check("b2b_04", 8'h04);
`else
        check("b2b_overruns", ov_cnt - ov0, 4);
        pop_check("b2b_01", 8'h01);
`endif
        check("b2b_empty", bus.rx_valid, 1'b0);
        check("pulses_single_cycle", pulse_long, 0);
        check("no_stray_frame_err", fe_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
